// File: rtl/alu_issue_seq_if.sv
// Issue handshake between decode and the ALU sequencer.
// Decode drives the master side, the sequencer the slave side.
interface alu_issue_seq_if #(
  parameter int REG_AW = 4
);
  logic              valid;
  logic              ready;
  logic [3:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic              eq;
  logic [2:0]        ltgt;

  modport master (
    output valid, op, rd, rs, eq, ltgt,
    input  ready
  );

  modport slave (
    input  valid, op, rd, rs, eq, ltgt,
    output ready
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Multi-cycle ALU issue sequencer: read operands, hold them on the
// ALU for EXEC_CYCLES, then retire as a register write or branch strobe.
module alu_issue_seq #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  alu_issue_seq_if.slave    issue,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] alu_register,
  output logic              alu_eq,
  output logic [2:0]        alu_ltgt,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_compres,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              br_valid,
  output logic              br_taken,
  output logic              illegal,
  output logic              busy
);

  localparam int CW =
    (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, READ, EXEC, WB
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic              eq;
    logic [2:0]        ltgt;
  } instr_t;

  state_t        state;
  instr_t        ins;
  logic [CW-1:0] cnt;
  logic          ready_q;

  assign issue.ready = ready_q;
  assign rf_raddr_a  = ins.rd;
  assign rf_raddr_b  = ins.rs;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ins          <= '0;
      cnt          <= '0;
      ready_q      <= 1'b1;
      busy         <= 1'b0;
      alu_op       <= '0;
      alu_res      <= '0;
      alu_register <= '0;
      alu_eq       <= 1'b0;
      alu_ltgt     <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      br_valid     <= 1'b0;
      br_taken     <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      br_valid <= 1'b0;
      br_taken <= 1'b0;
      illegal  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue.valid) begin
            ins <= '{op:   issue.op,
                     rd:   issue.rd,
                     rs:   issue.rs,
                     eq:   issue.eq,
                     ltgt: issue.ltgt};
            state   <= READ;
            ready_q <= 1'b0;
            busy    <= 1'b1;
          end
        end
        READ: begin
          alu_op       <= ins.op;
          alu_res      <= rf_rdata_a;
          alu_register <= rf_rdata_b;
          alu_eq       <= ins.eq;
          alu_ltgt     <= ins.ltgt;
          cnt          <= CNT_INIT;
          state        <= EXEC;
        end
        EXEC: begin
          if (cnt == '0) begin
            state    <= WB;
            rf_waddr <= ins.rd;
            rf_wdata <= alu_out;
            // retire class decides which single strobe fires in WB
            unique case (1'b1)
              (ins.op < 4'd5): rf_we <= 1'b1;
              (ins.op == 4'd5): begin
                br_valid <= 1'b1;
                br_taken <= alu_compres;
              end
              default: illegal <= 1'b1;
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WB: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized bench for alu_issue_seq: two instances (EXEC_CYCLES 1 and 3)
// against a transaction-level register-file and ALU reference model.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        v    [2];
  logic [3:0]  opv  [2];
  logic [3:0]  rdv  [2];
  logic [3:0]  rsv  [2];
  logic        eqv  [2];
  logic [2:0]  ltv  [2];
  logic        rdy  [2];

  logic [3:0]  ra   [2];
  logic [3:0]  rb   [2];
  logic [3:0]  aop  [2];
  logic [15:0] ares [2];
  logic [15:0] areg [2];
  logic        aeq  [2];
  logic [2:0]  alt  [2];
  logic [15:0] aout [2];
  logic        acmp [2];
  logic        we   [2];
  logic [3:0]  wad  [2];
  logic [15:0] wdat [2];
  logic        bv   [2];
  logic        bt   [2];
  logic        ill  [2];
  logic        bsy  [2];

  logic [15:0] rf  [2][16];
  logic [15:0] mrf [2][16];

  logic        pl_we = 1'b0;
  int          pl_d  = 0;
  logic [3:0]  pl_a  = '0;
  logic [15:0] pl_v  = '0;

  int          cyc = 0;
  int          acc_n    [2] = '{0, 0};
  int          acc_last [2] = '{0, 0};
  int          acc_prev [2] = '{0, 0};

  int          checks = 0;
  int          errors = 0;
  logic        seen_bt;

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_f(
    input logic [3:0]  op,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        e,
    input logic [2:0]  l
  );
    logic [15:0] o;
    logic        c;
    o = '0;
    c = 1'b0;
    case (op)
      4'd0: o = a + b;
      4'd1: o = a - b;
      4'd2: o = a & b;
      4'd3: o = a | b;
      4'd4: o = {15'd0, ^a};
      default: o = '0;
    endcase
    if (e) begin
      if (l == 3'd0) c = (a == b);
      else if (l == 3'd1) c = (a <= b);
      else if (l == 3'd2) c = (a >= b);
    end else begin
      if (l == 3'd0) c = (a != b);
      else if (l == 3'd1) c = (a < b);
      else if (l == 3'd2) c = (a > b);
    end
    return {c, o};
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g
    alu_issue_seq_if #(.REG_AW(4)) ifc ();
    assign ifc.valid = v[d];
    assign ifc.op    = opv[d];
    assign ifc.rd    = rdv[d];
    assign ifc.rs    = rsv[d];
    assign ifc.eq    = eqv[d];
    assign ifc.ltgt  = ltv[d];
    assign rdy[d]    = ifc.ready;
    assign {acmp[d], aout[d]} =
      alu_f(aop[d], ares[d], areg[d], aeq[d], alt[d]);

    alu_issue_seq #(
      .DATA_W(16),
      .REG_AW(4),
      .EXEC_CYCLES(d ? 3 : 1)
    ) dut (
      .clock(clk),
      .reset_n(rst_n),
      .issue(ifc),
      .rf_raddr_a(ra[d]),
      .rf_raddr_b(rb[d]),
      .rf_rdata_a(rf[d][ra[d]]),
      .rf_rdata_b(rf[d][rb[d]]),
      .alu_op(aop[d]),
      .alu_res(ares[d]),
      .alu_register(areg[d]),
      .alu_eq(aeq[d]),
      .alu_ltgt(alt[d]),
      .alu_out(aout[d]),
      .alu_compres(acmp[d]),
      .rf_we(we[d]),
      .rf_waddr(wad[d]),
      .rf_wdata(wdat[d]),
      .br_valid(bv[d]),
      .br_taken(bt[d]),
      .illegal(ill[d]),
      .busy(bsy[d])
    );
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (we[d]) rf[d][wad[d]] <= wdat[d];
      if (v[d] && rdy[d]) begin
        acc_n[d]    <= acc_n[d] + 1;
        acc_prev[d] <= acc_last[d];
        acc_last[d] <= cyc;
      end
    end
    if (pl_we) rf[pl_d][pl_a] <= pl_v;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic setr(input int d, input logic [3:0] a,
                      input logic [15:0] val);
    @(negedge clk);
    pl_we = 1'b1;
    pl_d  = d;
    pl_a  = a;
    pl_v  = val;
    mrf[d][a] = val;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic issue(input int d, input logic [3:0] op,
                       input logic [3:0] rd, input logic [3:0] rs,
                       input logic e, input logic [2:0] l);
    logic [16:0] r;
    int ec;
    int n;
    logic wb;
    ec = d ? 3 : 1;
    r  = alu_f(op, mrf[d][rd], mrf[d][rs], e, l);
    @(negedge clk);
    n = 0;
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rdy_wait", 32'(rdy[d]), 32'd1);
    v[d] = 1'b1; opv[d] = op; rdv[d] = rd;
    rsv[d] = rs; eqv[d] = e; ltv[d] = l;
    @(posedge clk);
    #1;
    v[d]   = 1'b0;
    opv[d] = 4'($urandom);
    rdv[d] = 4'($urandom);
    rsv[d] = 4'($urandom);
    eqv[d] = 1'($urandom);
    ltv[d] = 3'($urandom);
    check("acc_busy", 32'(bsy[d]), 32'd1);
    check("acc_rdy", 32'(rdy[d]), 32'd0);
    check("raddr_a", 32'(ra[d]), 32'(rd));
    check("raddr_b", 32'(rb[d]), 32'(rs));
    for (int k = 1; k <= ec + 2; k++) begin
      @(posedge clk);
      #1;
      wb = (k == ec + 1);
      check("we", 32'(we[d]), 32'(wb && op < 4'd5));
      check("bv", 32'(bv[d]), 32'(wb && op == 4'd5));
      check("ill", 32'(ill[d]), 32'(wb && op > 4'd5));
      check("rdy", 32'(rdy[d]), 32'(k == ec + 2));
      if (k <= ec) begin
        check("alu_op", 32'(aop[d]), 32'(op));
        check("alu_res", 32'(ares[d]), 32'(mrf[d][rd]));
        check("alu_reg", 32'(areg[d]), 32'(mrf[d][rs]));
        check("alu_eq", 32'(aeq[d]), 32'(e));
        check("alu_ltgt", 32'(alt[d]), 32'(l));
      end
      if (wb && op < 4'd5) begin
        check("waddr", 32'(wad[d]), 32'(rd));
        check("wdata", 32'(wdat[d]), 32'(r[15:0]));
        mrf[d][rd] = r[15:0];
      end
      if (wb && op == 4'd5) begin
        check("taken", 32'(bt[d]), 32'(r[16]));
        seen_bt = bt[d];
      end
    end
  endtask

  task automatic b2b(input int d, input int sp);
    int n0;
    int n;
    n0 = acc_n[d];
    @(negedge clk);
    opv[d] = 4'd5; rdv[d] = 4'd5; rsv[d] = 4'd6;
    eqv[d] = 1'b0; ltv[d] = 3'd1;
    v[d] = 1'b1;
    n = 0;
    while (acc_n[d] < n0 + 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    v[d] = 1'b0;
    check("b2b_cnt", 32'(acc_n[d] - n0), 32'd2);
    check("b2b_sp", 32'(acc_last[d] - acc_prev[d]), 32'(sp));
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic flag;
    for (int d = 0; d < 2; d++) begin
      v[d] = 1'b0; opv[d] = '0; rdv[d] = '0;
      rsv[d] = '0; eqv[d] = 1'b0; ltv[d] = '0;
    end
    seen_bt = 1'b0;
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check("rst_rdy", 32'(rdy[d]), 32'd1);
      check("rst_busy", 32'(bsy[d]), 32'd0);
      check("rst_we", 32'(we[d]), 32'd0);
      check("rst_bv", 32'(bv[d]), 32'd0);
      check("rst_bt", 32'(bt[d]), 32'd0);
      check("rst_ill", 32'(ill[d]), 32'd0);
      check("rst_aop", 32'(aop[d]), 32'd0);
      check("rst_ares", 32'(ares[d]), 32'd0);
      check("rst_ra", 32'(ra[d]), 32'd0);
      check("rst_wdata", 32'(wdat[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        setr(d, 4'(i), 16'($urandom));

    setr(0, 4'd3, 16'h0005);
    setr(0, 4'd4, 16'h0007);
    issue(0, 4'd0, 4'd3, 4'd4, 1'b0, 3'd0);
    check("add_c", 32'(rf[0][3]), 32'h000C);
    setr(0, 4'd1, 16'h0000);
    setr(0, 4'd2, 16'h0001);
    issue(0, 4'd1, 4'd1, 4'd2, 1'b0, 3'd0);
    check("sub_wrap", 32'(rf[0][1]), 32'hFFFF);
    setr(0, 4'd1, 16'h0007);
    issue(0, 4'd4, 4'd1, 4'd1, 1'b0, 3'd0);
    check("parity", 32'(rf[0][1]), 32'h0001);
    setr(0, 4'd5, 16'h0010);
    setr(0, 4'd6, 16'h0020);
    issue(0, 4'd5, 4'd5, 4'd6, 1'b0, 3'd1);
    check("br_lt", 32'(seen_bt), 32'd1);
    issue(0, 4'd5, 4'd5, 4'd6, 1'b1, 3'd0);
    check("br_eq", 32'(seen_bt), 32'd0);
    issue(0, 4'd9, 4'd2, 4'd3, 1'b0, 3'd0);
    issue(0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0);

    b2b(0, 4);
    b2b(1, 6);
    issue(1, 4'd0, 4'd3, 4'd4, 1'b0, 3'd0);

    // abort an EXEC-phase instruction on the 3-cycle instance
    @(negedge clk);
    v[1] = 1'b1; opv[1] = 4'd0; rdv[1] = 4'd7;
    rsv[1] = 4'd8; eqv[1] = 1'b0; ltv[1] = 3'd0;
    @(posedge clk);
    #1 v[1] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rdy", 32'(rdy[1]), 32'd1);
    check("arst_busy", 32'(bsy[1]), 32'd0);
    check("arst_ares", 32'(ares[1]), 32'd0);
    check("arst_ra", 32'(ra[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 flag = flag | we[1] | bv[1] | ill[1] | we[0];
    end
    check("arst_quiet", 32'(flag), 32'd0);
    issue(1, 4'd0, 4'd7, 4'd8, 1'b0, 3'd0);

    for (int i = 0; i < 48; i++) begin
      int d;
      logic [3:0] op;
      d  = (i % 4 == 3) ? 1 : 0;
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5))
                                      : 4'($urandom_range(6, 15));
      if ($urandom_range(0, 2) == 0)
        setr(d, 4'($urandom), 16'($urandom));
      issue(d, op, 4'($urandom), 4'($urandom),
            1'($urandom), 3'($urandom_range(0, 3)));
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        check("rf_final", 32'(rf[d][i]), 32'(mrf[d][i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Sequencer on the issuing side of the ALU interface: accepts one decoded ALU instruction through a valid/ready handshake.
- Reads both source registers, drives op/operands/compare controls into the combinational ALU, holds them while it settles, then captures out/compres.
- Retires each instruction as either one register-file write or one branch-resolution pulse.
- Sits between decode and the ALU/register file in the multi-cycle datapath.

Parameters:
DATA_W, 16, operand/result width
REG_AW, 4, register-file address width
EXEC_CYCLES, 1, cycles operands are held on the ALU before sampling (legal range >=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
issue_valid  in  1  decode presents an instruction
issue_ready  out  1  sequencer can accept
issue_op  in  4  0 add, 1 sub, 2 and, 3 or, 4 even-parity, 5 branch compare, 6-15 illegal
issue_rd  in  REG_AW  destination register
issue_rs  in  REG_AW  second source register (first source is issue_rd)
issue_eq  in  1  compare class: 1 = {==,<=,>=}, 0 = {!=,<,>}
issue_ltgt  in  3  compare select within class: 0,1,2
rf_raddr_a  out  REG_AW  register-file read address, operand res
rf_raddr_b  out  REG_AW  register-file read address, operand register
rf_rdata_a  in  DATA_W  combinational read data A
rf_rdata_b  in  DATA_W  combinational read data B
alu_op  out  4  to ALU op
alu_res  out  DATA_W  to ALU res
alu_register  out  DATA_W  to ALU register
alu_eq  out  1  to ALU eq
alu_ltgt  out  3  to ALU ltgt
alu_out  in  DATA_W  ALU result
alu_compres  in  1  ALU compare result
rf_we  out  1  one-cycle write strobe
rf_waddr  out  REG_AW  write address
rf_wdata  out  DATA_W  write data
br_valid  out  1  one-cycle branch-resolved strobe
br_taken  out  1  compare outcome, qualified by br_valid
illegal  out  1  one-cycle strobe, illegal op retired
busy  out  1  high in any state except IDLE

Behaviour:
- States: IDLE, READ, EXEC, WB. Reset (async, reset_n low) forces IDLE.
- Reset values: all outputs 0 except issue_ready=1. Exec counter and all latched fields are 0.
- issue_ready = 1 only in IDLE; transfer occurs on a rising edge with issue_valid & issue_ready.
- IDLE -> READ on transfer: latch op, rd, rs, eq, ltgt. rf_raddr_a=rd and rf_raddr_b=rs are driven from latched fields and held until IDLE.
- READ (1 cycle): at its closing edge capture rf_rdata_a/b into operand regs. -> EXEC, counter=EXEC_CYCLES-1.
- EXEC: alu_op, alu_res, alu_register, alu_eq and alu_ltgt are driven from latched regs, stable for all EXEC cycles.
  - Counter decrements each edge.
  - On the edge where counter==0, capture alu_out and alu_compres. -> WB.
- Outside EXEC, alu_* hold their last values; they are not zeroed.
- WB (1 cycle), then -> IDLE:
  - op 0-4: rf_we=1, rf_waddr=rd, rf_wdata=captured result.
  - op 5: br_valid=1, br_taken=captured compres, rf_we=0.
  - op 6-15: illegal=1; no write, no branch strobe.
- Latency: rf_we/br_valid are high in the cycle following edge E0+1+EXEC_CYCLES, where E0 is the accepting edge.
  - Throughput: one instruction per 3+EXEC_CYCLES cycles.
  - No overlap: issue_ready stays low through WB.
- Compare encoding for op 5:
  - eq=1: ltgt 0 ==, 1 <=, 2 >=.
  - eq=0: ltgt 0 !=, 1 <, 2 >.
  - ltgt>=3 is passed through unchanged; br_taken reflects whatever alu_compres reads.
- Widths: no arithmetic in this block; data passes unmodified. The add/sub wrap-around is the ALU's and is written back as-is.
- rd==rs is legal; both operands read the same register. rd=0 is written like any other register.
- issue_valid held high in non-IDLE states is ignored; fields may change freely without effect.
- reset_n low mid-instruction: immediate return to IDLE; no rf_we, br_valid or illegal pulse for the aborted instruction.

Test Plan:
- Add: r3=0x0005, r4=0x0007, op0 rd=3 rs=4 -> rf_we one cycle at E0+2 (EXEC_CYCLES=1), waddr=3, wdata=0x000C; issue_ready low E0..WB.
- Sub wrap: r1=0x0000, r2=0x0001, op1 -> wdata=0xFFFF. Parity op4 with r1=0x0007 -> wdata=0x0001.
- Branch: r5=0x0010, r6=0x0020, op5 eq=0 ltgt=1 -> br_valid one cycle, br_taken=1, rf_we never high; eq=1 ltgt=0 -> br_taken=0.
- Back-to-back with issue_valid held high: two ops accepted exactly 4 cycles apart; EXEC_CYCLES=3 -> alu_* stable 3 cycles, spacing 6.
- Illegal op 9 -> illegal pulse, rf_we=0, br_valid=0, return to IDLE.
- reset_n low during EXEC -> outputs return to reset values asynchronously; no strobes; next issue behaves normally.
